// File: rtl/fetch_control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cu_pkg                                                     |
// | Shared state encoding, opcode constants and IR field positions for   |
// | the TCC fetch control unit.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cu_pkg;

  localparam int OPCODE_WIDTH = 5;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b11111;

  localparam int IR_WIDTH       = 16;
  localparam int IR_OPCODE_MSB  = 15;
  localparam int IR_OPCODE_LSB  = 11;
  localparam int IR_OPERAND_MSB = 10;
  localparam int IR_OPERAND_LSB = 0;

  localparam int TIMEOUT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    FETCH    = 3'd2,
    LOAD     = 3'd3,
    DECODE   = 3'd4,
    DISPATCH = 3'd5,
    HALT     = 3'd6,
    ERROR    = 3'd7
  } cu_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_timeout_counter                                      |
// | Clear/enable up-counter flagging a terminal count for the memory     |
// | watchdog of the fetch control unit.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_timeout_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/fetch_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_control_unit                                         |
// | Moore FSM sequencing IR clear, memory fetch, IR load/PC increment    |
// | and valid/ready dispatch; stops on HALT. Optional memory watchdog    |
// | enabled by defining CU_TIMEOUT_EN.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_control_unit #(
  parameter int                      OPCODE_WIDTH = cu_pkg::OPCODE_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = cu_pkg::HALT_OPCODE,
  parameter int                      MEM_TIMEOUT  = 15,
  parameter int                      COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    cu_reset,
  input  logic                    cu_start,
  output logic                    mem_rd,
  input  logic                    mem_ack,
  output logic                    ir_wr,
  output logic                    ir_reset,
  output logic                    pc_inc,
  input  logic [OPCODE_WIDTH-1:0] ir_opcode,
  output logic                    dispatch_valid,
  input  logic                    dispatch_ready,
  output logic                    cu_halted,
  output logic                    cu_error,
  output logic [COUNT_WIDTH-1:0]  instr_count
);

  import cu_pkg::*;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || COUNT_WIDTH < 1 ||
      OPCODE_WIDTH != IR_OPCODE_MSB - IR_OPCODE_LSB + 1 ||
      IR_OPCODE_MSB != IR_WIDTH - 1 || IR_OPERAND_MSB + 1 != IR_OPCODE_LSB ||
      IR_OPERAND_LSB != 0) begin : g_param_check
    $error("fetch_control_unit: illegal parameterisation");
  end

  cu_state_e state;
  cu_state_e next_state;
  logic      clear_phase;
  logic      timeout_hit;

`ifdef CU_TIMEOUT_EN
  logic error_flag;

  // Counter holds at zero outside FETCH, so every entry to FETCH starts fresh.
  fetch_timeout_counter #(
    .WIDTH    (TIMEOUT_WIDTH),
    .TERMINAL (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clock),
    .rst      (cu_reset),
    .clear    (state != FETCH),
    .enable   ((state == FETCH) && !mem_ack),
    .terminal (timeout_hit)
  );

  assign cu_error = error_flag;
`else
  assign timeout_hit = 1'b0;
  assign cu_error    = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (cu_start) next_state = CLEAR;
      CLEAR:    next_state = FETCH;
      FETCH: begin
        if (mem_ack)          next_state = LOAD;
        else if (timeout_hit) next_state = ERROR;
      end
      LOAD:     next_state = DECODE;
      DECODE:   next_state = (ir_opcode == HALT_OPCODE) ? HALT : DISPATCH;
      DISPATCH: if (dispatch_ready) next_state = FETCH;
      HALT:     next_state = HALT;
      ERROR:    next_state = ERROR;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they always match the state register.
  always_ff @(posedge clock) begin
    if (cu_reset) begin
      state          <= IDLE;
      clear_phase    <= 1'b0;
      mem_rd         <= 1'b0;
      ir_wr          <= 1'b0;
      pc_inc         <= 1'b0;
      dispatch_valid <= 1'b0;
      cu_halted      <= 1'b0;
      instr_count    <= '0;
`ifdef CU_TIMEOUT_EN
      error_flag     <= 1'b0;
`endif
    end else begin
      state          <= next_state;
      clear_phase    <= (next_state == CLEAR);
      mem_rd         <= (next_state == FETCH);
      ir_wr          <= (next_state == LOAD);
      pc_inc         <= (next_state == LOAD);
      dispatch_valid <= (next_state == DISPATCH);
      cu_halted      <= (next_state == HALT);
`ifdef CU_TIMEOUT_EN
      error_flag     <= (next_state == ERROR);
`endif
      if ((state == DISPATCH) && dispatch_ready && (instr_count != '1)) begin
        instr_count <= instr_count + 1'b1;
      end
    end
  end

  assign ir_reset = clear_phase | cu_reset;

endmodule
`default_nettype wire

// File: tb/tb_fetch_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fetch_control_unit                                      |
// | Self-checking bench: transaction-level model plus directed vectors.  |
// | Watchdog vectors follow CU_TIMEOUT_EN.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_control_unit;

  localparam int TB_MEM_TIMEOUT = 15;
`ifdef CU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        cu_reset, cu_start, mem_ack, dispatch_ready;
  logic [4:0]  ir_opcode;
  logic        mem_rd, ir_wr, ir_reset, pc_inc, dispatch_valid, cu_halted, cu_error;
  logic [15:0] instr_count;

  always #5 clock = ~clock;

  fetch_control_unit #(
    .OPCODE_WIDTH (5),
    .HALT_OPCODE  (5'b11111),
    .MEM_TIMEOUT  (TB_MEM_TIMEOUT),
    .COUNT_WIDTH  (16)
  ) dut (
    .clock          (clock),
    .cu_reset       (cu_reset),
    .cu_start       (cu_start),
    .mem_rd         (mem_rd),
    .mem_ack        (mem_ack),
    .ir_wr          (ir_wr),
    .ir_reset       (ir_reset),
    .pc_inc         (pc_inc),
    .ir_opcode      (ir_opcode),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .cu_halted      (cu_halted),
    .cu_error       (cu_error),
    .instr_count    (instr_count)
  );

  // Environment: instruction ROM, PC, IR, and memory / execute responders.
  logic [15:0] rom [0:31];
  logic [15:0] ir;
  logic [4:0]  pc;
  int wcnt = 0, vcnt = 0, ack_delay = 0, ready_delay = 0;

  assign mem_ack        = mem_rd && (wcnt >= ack_delay);
  assign dispatch_ready = dispatch_valid && (vcnt >= ready_delay);
  assign ir_opcode      = ir[15:11];

  always @(posedge clock) begin
    if (cu_reset) pc <= 5'd0;
    else if (pc_inc) pc <= pc + 5'd1;
    if (ir_reset) ir <= 16'h0000;
    else if (ir_wr) ir <= rom[pc];
    wcnt <= mem_rd ? wcnt + 1 : 0;
    vcnt <= dispatch_valid ? vcnt + 1 : 0;
  end

  // Behavioural model: running flag plus position within one instruction's life.
  // step 0 clear, 1 waiting on memory, 2 load, 3 decode, 4 offered to execute.
  bit m_active, m_halted, m_error;
  int m_step, m_wait, m_count;

  always @(posedge clock) begin
    if (cu_reset) begin
      m_active <= 0; m_halted <= 0; m_error <= 0;
      m_step <= 0; m_wait <= 0; m_count <= 0;
    end else if (m_active) begin
      case (m_step)
        0: begin m_step <= 1; m_wait <= 0; end
        1: if (mem_ack) m_step <= 2;
           else if (TO_EN && m_wait == TB_MEM_TIMEOUT) begin m_active <= 0; m_error <= 1; end
           else m_wait <= m_wait + 1;
        2: m_step <= 3;
        3: if (ir_opcode == 5'b11111) begin m_active <= 0; m_halted <= 1; end
           else m_step <= 4;
        4: if (dispatch_ready) begin
             m_step <= 1; m_wait <= 0;
             if (m_count < 65535) m_count <= m_count + 1;
           end
        default: ;
      endcase
    end else if (!m_halted && !m_error && cu_start) begin
      m_active <= 1; m_step <= 0;
    end
  end

  int checks = 0, errors = 0;
  bit cmp_en = 0;
  int n_mem_rd, n_ir_wr, n_pc_inc, n_dv, n_ir_reset;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_mem_rd = 0; n_ir_wr = 0; n_pc_inc = 0; n_dv = 0; n_ir_reset = 0;
  endtask

  // One cycle: compare against the model on the falling edge, then step past the rising edge.
  task automatic tick();
    logic [6:0] act, exp;
    @(negedge clock);
    if (cmp_en) begin
      act = {mem_rd, ir_wr, ir_reset, pc_inc, dispatch_valid, cu_halted, cu_error};
      exp = {m_active && m_step == 1, m_active && m_step == 2,
             cu_reset || (m_active && m_step == 0), m_active && m_step == 2,
             m_active && m_step == 4, m_halted, m_error};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, exp);
      end
      checks++;
      if (instr_count !== 16'(m_count)) begin
        errors++;
        $display("FAIL instr_count t=%0t actual=%0d required=%0d", $time, instr_count, m_count);
      end
      n_mem_rd   += mem_rd ? 1 : 0;
      n_ir_wr    += ir_wr ? 1 : 0;
      n_pc_inc   += pc_inc ? 1 : 0;
      n_dv       += dispatch_valid ? 1 : 0;
      n_ir_reset += ir_reset ? 1 : 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cu_reset = 1'b1;
    tick();
    tick();
    check("reset_ir_reset", ir_reset, 1);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_count", instr_count, 0);
    cu_reset = 1'b0;
  endtask

  task automatic start();
    cu_start = 1'b1;
    tick();
    cu_start = 1'b0;
  endtask

  initial begin
    cu_reset = 1'b1; cu_start = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = {5'b00101, 11'(i)};
    tick();
    cmp_en = 1;
    do_reset();

    // Zero-wait memory, ready execute stage: latency and 4-cycle steady state.
    clr_counts();
    start();
    check("t1_ir_reset_n1", ir_reset, 1);
    check("t1_mem_rd_n1", mem_rd, 0);
    tick();
    check("t1_mem_rd_n2", mem_rd, 1);
    tick();
    check("t1_ir_wr_n3", ir_wr, 1);
    check("t1_pc_inc_n3", pc_inc, 1);
    tick(); tick();
    check("t1_dv_n5", dispatch_valid, 1);
    repeat (9) tick();
    check("t1_count", instr_count, 3);
    check("t1_ir_wr_pulses", n_ir_wr, 3);
    check("t1_dv_cycles", n_dv, 3);
    check("t1_ir_reset_cycles", n_ir_reset, 1);

    // Wait-state memory.
    do_reset();
    ack_delay = 3;
    clr_counts();
    start();
    for (int i = 0; i < 40 && instr_count != 16'd1; i++) tick();
    check("t2_count", instr_count, 1);
    check("t2_mem_rd_cycles", n_mem_rd, 4);
    check("t2_ir_wr_pulses", n_ir_wr, 1);
    check("t2_pc_inc_pulses", n_pc_inc, 1);

    // Back-pressure from the execute stage.
    do_reset();
    ack_delay = 0; ready_delay = 5;
    clr_counts();
    start();
    for (int i = 0; i < 40 && instr_count != 16'd1; i++) tick();
    check("t3_count", instr_count, 1);
    check("t3_dv_cycles", n_dv, 6);
    check("t3_mem_rd_cycles", n_mem_rd, 1);

    // HALT as the third instruction.
    rom[2] = {5'b11111, 11'd0};
    do_reset();
    ready_delay = 0;
    clr_counts();
    start();
    for (int i = 0; i < 60 && cu_halted !== 1'b1; i++) tick();
    check("t4_halted", cu_halted, 1);
    check("t4_count", instr_count, 2);
    check("t4_fetches", n_mem_rd, 3);
    check("t4_dispatches", n_dv, 2);
    clr_counts();
    cu_start = 1'b1; tick(); tick(); cu_start = 1'b0;
    repeat (8) tick();
    check("t4_still_halted", cu_halted, 1);
    check("t4_no_fetch", n_mem_rd, 0);
    check("t4_no_clear", n_ir_reset, 0);
    check("t4_count_hold", instr_count, 2);
    rom[2] = {5'b00101, 11'd2};

    // Reset while an instruction is being offered.
    do_reset();
    start();
    for (int i = 0; i < 40 && instr_count != 16'd2; i++) tick();
    ready_delay = 1000;
    for (int i = 0; i < 20 && dispatch_valid !== 1'b1; i++) tick();
    check("t5_in_dispatch", dispatch_valid, 1);
    check("t5_count_before", instr_count, 2);
    cu_reset = 1'b1;
    tick();
    check("t5_dv", dispatch_valid, 0);
    check("t5_mem_rd", mem_rd, 0);
    check("t5_ir_reset", ir_reset, 1);
    check("t5_count", instr_count, 0);
    tick();
    check("t5_ir_reset_held", ir_reset, 1);
    cu_reset = 1'b0; ready_delay = 0;
    tick();
    check("t5_ir_reset_release", ir_reset, 0);

    // Memory that never acknowledges.
    do_reset();
    ack_delay = 1000;
    clr_counts();
    start();
`ifdef CU_TIMEOUT_EN
    for (int i = 0; i < 40 && cu_error !== 1'b1; i++) tick();
    check("t6_error", cu_error, 1);
    check("t6_fetch_cycles", n_mem_rd, 16);
    check("t6_mem_rd_off", mem_rd, 0);
    do_reset();
    check("t6_error_cleared", cu_error, 0);
    ack_delay = 15;
    clr_counts();
    start();
    for (int i = 0; i < 60 && instr_count != 16'd1; i++) tick();
    check("t6_late_ack_count", instr_count, 1);
    check("t6_late_ack_fetch", n_mem_rd, 16);
    check("t6_late_ack_no_error", cu_error, 0);
`else
    repeat (40) tick();
    check("t6_no_error", cu_error, 0);
    check("t6_still_fetching", mem_rd, 1);
    check("t6_fetch_cycles", n_mem_rd, 39);
`endif
    ack_delay = 0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_control_unit.md
Name: fetch_control_unit

Overview:
- Moore FSM that sequences the 16-bit instruction register and the instruction fetch path of the TCC processor.
- Clears the IR, issues memory reads with an ack handshake, loads the IR and increments the PC.
- Presents each fetched instruction to the execute stage over a valid/ready handshake.
- Stops on the HALT opcode; an optional watchdog flags a memory that never acknowledges.

Parameters:
- OPCODE_WIDTH, 5: width of ir_opcode, which is ir_out[15:11].
- HALT_OPCODE, 5'b11111: opcode that stops fetching.
- MEM_TIMEOUT, 15: FETCH cycles without mem_ack before the error state; legal range is 1 to 255.
- COUNT_WIDTH, 16: width of the dispatched-instruction counter.

Ports:
- clock  in  1: single system clock; all logic on the rising edge.
- cu_reset  in  1: synchronous, active-high reset.
- cu_start  in  1: begin fetching; sampled only in IDLE.
- mem_rd  out  1: instruction memory read request.
- mem_ack  in  1: memory data valid; sampled only while mem_rd=1.
- ir_wr  out  1: IR load strobe.
- ir_reset  out  1: IR clear.
- pc_inc  out  1: PC increment strobe.
- ir_opcode  in  OPCODE_WIDTH: opcode field of the IR output.
- dispatch_valid  out  1: instruction in the IR is ready for the execute stage.
- dispatch_ready  in  1: execute stage accepts the instruction.
- cu_halted  out  1: HALT opcode reached.
- cu_error  out  1: memory timeout.
- instr_count  out  COUNT_WIDTH: number of dispatched instructions.

Behaviour:
- Synchronous, active-high reset on cu_reset.
  - The reset clock edge forces state IDLE, instr_count=0 and the timeout counter to 0.
  - It overrides every other input, including mid-fetch and mid-dispatch.
  - ir_reset = (state==CLEAR) OR cu_reset, so the IR clears together with the controller.
- All other outputs are decoded from state only (Moore). With cu_reset held, every output is 0 except ir_reset=1.
- State IDLE: outputs 0. cu_start=1 -> CLEAR.
- State CLEAR: ir_reset=1 for exactly one cycle -> FETCH.
- State FETCH: mem_rd=1.
  - mem_ack=1 -> LOAD.
  - Otherwise stay in FETCH and increment the timeout counter.
  - The timeout counter clears on every entry to FETCH.
- State LOAD: ir_wr=1 and pc_inc=1 for exactly one cycle -> DECODE.
- State DECODE: one settle cycle, since the IR output is valid after the LOAD edge.
  - ir_opcode==HALT_OPCODE -> HALT.
  - Otherwise -> DISPATCH.
- State DISPATCH: dispatch_valid=1, held stable until dispatch_ready=1.
  - On the handshake cycle: instr_count increments, then -> FETCH.
  - dispatch_ready is ignored in all other states.
- State HALT: cu_halted=1. Terminal; only cu_reset leaves it. cu_start is ignored. A HALT instruction is never dispatched or counted.
- State ERROR: cu_error=1. Terminal until cu_reset.
- Latency:
  - cu_start high at edge N: ir_reset high in cycle N+1, first mem_rd in cycle N+2.
  - With mem_ack returned in the same cycle: ir_wr in N+3, dispatch_valid from N+5.
  - Steady state is 4 cycles per instruction with zero-wait memory and a ready execute stage.
- instr_count saturates at all-ones and does not wrap.
- cu_start high in any state other than IDLE has no effect.

Optional Feature:
- Macro: CU_TIMEOUT_EN.
- Defined:
  - An 8-bit timeout counter is active in FETCH.
  - When the counter equals MEM_TIMEOUT and mem_ack=0 -> ERROR.
  - mem_ack=1 in that same cycle wins -> LOAD.
- Undefined:
  - FETCH waits indefinitely.
  - ERROR state and counter are not built; cu_error is tied to 0.

Decomposition:
- Package cu_pkg:
  - state enum: IDLE, CLEAR, FETCH, LOAD, DECODE, DISPATCH, HALT, ERROR.
  - OPCODE_WIDTH and HALT_OPCODE constants.
  - IR field positions: opcode [15:11], operand [10:0].
- Sub-module fetch_timeout_counter: clear/enable/terminal-count counter, instantiated only under CU_TIMEOUT_EN.
- Everything else stays in one module.

Test Plan:
- Reset then start: cu_reset=1 for 2 cycles, cu_start pulse, mem_ack tied 1, dispatch_ready tied 1, opcode 5'b00101 -> ir_reset 1 cycle, mem_rd next, ir_wr/pc_inc one cycle, dispatch_valid one cycle; instr_count=3 after 12 cycles of fetching.
- Wait-state memory: mem_ack delayed 3 cycles -> mem_rd held high for 4 cycles, single ir_wr, single pc_inc.
- Back-pressure: dispatch_ready low 5 cycles -> dispatch_valid held 6 cycles, no mem_rd meanwhile, instr_count increments once.
- HALT: third instruction has opcode 5'b11111 -> cu_halted=1, instr_count stays 2, no further mem_rd; cu_start pulses ignored.
- Reset mid-operation: cu_reset asserted in DISPATCH -> next cycle all outputs 0, instr_count=0, ir_reset=1 while reset is held.
- Watchdog (CU_TIMEOUT_EN defined, MEM_TIMEOUT=15): no mem_ack -> cu_error=1 after 16 FETCH cycles; mem_ack on cycle 16 instead -> LOAD, cu_error stays 0.
